cmult_stream: RTL and testbench

CMULT_STREAM -- requirements
Module: cmult_stream

---
 rtl/cmult_pkg.sv | 13 +
 rtl/cmult_round_sat.sv | 48 ++++
 rtl/cmult_stream.sv | 141 ++++++++++++++
 tb/tb_cmult_stream.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// rtl/cmult_pkg.sv - shared constants and width helper for the complex multiplier stream
package cmult_pkg;

  // Stages from input transfer to m_valid; fixed for every parameter set.
  localparam int CMULT_LAT = 6;

  // Full-precision product width. Pre-adds grow one bit and the conjugate
  // negation grows B by one bit, so A+B+2 never wraps.
  function automatic int full_prod_width(input int aw, input int bw);
    return aw + bw + 2;
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// rtl/cmult_round_sat.sv - round half-up, arithmetic shift and saturate one product component
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IWIDTH = full_prod_width(16, 18),
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 15
) (
  input  logic signed [IWIDTH-1:0] din,
  output logic signed [OWIDTH-1:0] dout,
  output logic                     ovf
);

  // One guard bit so the rounding add can never wrap.
  localparam int RW = IWIDTH + 1;

  localparam logic signed [OWIDTH-1:0] OMAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH-1:0] OMIN = {1'b1, {(OWIDTH-1){1'b0}}};

  logic signed [RW-1:0]   rounded;
  logic signed [RW-1:0]   shifted;
  logic        [RW-OWIDTH:0] hi;

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
      assign rounded = RW'(din) + HALF;
    end else begin : g_nornd
      assign rounded = RW'(din);
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;

  // Everything from the output sign bit upward must agree, otherwise the value does not fit.
  assign hi = shifted[RW-1:OWIDTH-1];

  // Clamp to the output range and flag when clamping happened.
  always_comb begin
    ovf  = 1'b0;
    dout = shifted[OWIDTH-1:0];
    if (!((&hi) || !(|hi))) begin
      ovf  = 1'b1;
      dout = shifted[RW-1] ? OMIN : OMAX;
    end
  end

endmodule

// File: rtl/cmult_stream.sv
// rtl/cmult_stream.sv - pipelined 3-multiplier complex multiply with conj mode and ready/valid flow control
module cmult_stream
  import cmult_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 15,
  parameter int UWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [AWIDTH-1:0] ar,
  input  logic signed [AWIDTH-1:0] ai,
  input  logic signed [BWIDTH-1:0] br,
  input  logic signed [BWIDTH-1:0] bi,
  input  logic                     conj,
  input  logic        [UWIDTH-1:0] s_user,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OWIDTH-1:0] pr,
  output logic signed [OWIDTH-1:0] pi,
  output logic                     m_ovf,
  output logic        [UWIDTH-1:0] m_user
);

  localparam int PW  = full_prod_width(AWIDTH, BWIDTH);
  localparam int AW1 = AWIDTH + 1;
  localparam int BW1 = BWIDTH + 1;
  localparam int BW2 = BWIDTH + 2;

  logic ce;
  logic [CMULT_LAT-1:0] vld;

  // stage 1: registered operands, B imaginary already conjugated
  logic signed [AWIDTH-1:0] ar1, ai1;
  logic signed [BWIDTH-1:0] br1;
  logic signed [BW1-1:0]    bi1;
  logic        [UWIDTH-1:0] u1;
  // stage 2: pre-adds
  logic signed [AW1-1:0]    dab2;
  logic signed [BW2-1:0]    dbr2, sbr2;
  logic signed [BW1-1:0]    bi2;
  logic signed [AWIDTH-1:0] ar2, ai2;
  logic        [UWIDTH-1:0] u2;
  // stages 3 and 4: products and their pipeline copy
  logic signed [PW-1:0]     pc3, pr3, pi3;
  logic signed [PW-1:0]     pc4, pr4, pi4;
  logic        [UWIDTH-1:0] u3, u4;
  // stage 5: post-adds
  logic signed [PW-1:0]     re5, im5;
  logic        [UWIDTH-1:0] u5;
  // round/saturate results feeding the output register
  logic signed [OWIDTH-1:0] pr_n, pi_n;
  logic                     ovf_r, ovf_i;

  assign ce      = m_ready || !m_valid;
  // Reset flushes the pipeline, so input is always acceptable while it is held.
  assign s_ready = ce || rst;
  assign m_valid = vld[CMULT_LAT-1];

  // Valid bits move with the data; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (ce) begin
      vld <= {vld[CMULT_LAT-2:0], s_valid};
    end
  end

  // Multiplier stages 1-5; data registers are don't-care under a zero valid bit.
  always_ff @(posedge clk) begin
    if (ce) begin
      ar1  <= ar;
      ai1  <= ai;
      br1  <= br;
      bi1  <= conj ? -BW1'(bi) : BW1'(bi);
      u1   <= s_user;

      dab2 <= AW1'(ar1) - AW1'(ai1);
      dbr2 <= BW2'(br1) - BW2'(bi1);
      sbr2 <= BW2'(br1) + BW2'(bi1);
      bi2  <= bi1;
      ar2  <= ar1;
      ai2  <= ai1;
      u2   <= u1;

      pc3  <= PW'(dab2) * PW'(bi2);
      pr3  <= PW'(dbr2) * PW'(ar2);
      pi3  <= PW'(sbr2) * PW'(ai2);
      u3   <= u2;

      pc4  <= pc3;
      pr4  <= pr3;
      pi4  <= pi3;
      u4   <= u3;

      re5  <= pr4 + pc4;
      im5  <= pi4 + pc4;
      u5   <= u4;
    end
  end

  cmult_round_sat #(
    .IWIDTH (PW),
    .OWIDTH (OWIDTH),
    .SHIFT  (SHIFT)
  ) u_rs_re (
    .din  (re5),
    .dout (pr_n),
    .ovf  (ovf_r)
  );

  cmult_round_sat #(
    .IWIDTH (PW),
    .OWIDTH (OWIDTH),
    .SHIFT  (SHIFT)
  ) u_rs_im (
    .din  (im5),
    .dout (pi_n),
    .ovf  (ovf_i)
  );

  // Stage 6 output register: loads only real samples so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr     <= '0;
      pi     <= '0;
      m_ovf  <= 1'b0;
      m_user <= '0;
    end else if (ce && vld[CMULT_LAT-2]) begin
      pr     <= pr_n;
      pi     <= pi_n;
      m_ovf  <= ovf_r || ovf_i;
      m_user <= u5;
    end
  end

endmodule

// File: tb/tb_cmult_stream.sv
// tb/tb_cmult_stream.sv - directed self-checking bench for cmult_stream
module tb_cmult_stream;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] ar, ai;
  logic signed [17:0] br, bi;
  logic               conj;
  logic        [7:0]  s_user;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] pr, pi;
  logic               m_ovf;
  logic        [7:0]  m_user;

  int total = 0;
  int bad   = 0;

  cmult_stream #(
    .AWIDTH (16),
    .BWIDTH (18),
    .OWIDTH (16),
    .SHIFT  (15),
    .UWIDTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .ar      (ar),
    .ai      (ai),
    .br      (br),
    .bi      (bi),
    .conj    (conj),
    .s_user  (s_user),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .pr      (pr),
    .pi      (pi),
    .m_ovf   (m_ovf),
    .m_user  (m_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a_r, input int a_i, input int b_r, input int b_i, input bit cj, input int usr);
    ar     = 16'(a_r);
    ai     = 16'(a_i);
    br     = 18'(b_r);
    bi     = 18'(b_i);
    conj   = cj;
    s_user = 8'(usr);
  endtask

  // One isolated sample: latency, result, then a bubble that must hold the outputs.
  task automatic run_one(input string tag, input int a_r, input int a_i, input int b_r, input int b_i,
                         input bit cj, input int usr, input int epr, input int epi, input int eovf);
    int n;
    drive(a_r, a_i, b_r, b_i, cj, usr);
    s_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      n++;
    end while (!m_valid && n < 20);
    chk({tag, "_lat"}, n, 6);
    chk({tag, "_pr"}, pr, epr);
    chk({tag, "_pi"}, pi, epi);
    chk({tag, "_ovf"}, m_ovf, eovf);
    chk({tag, "_user"}, m_user, usr);
    @(posedge clk); #1;
    chk({tag, "_bubble_valid"}, m_valid, 0);
    chk({tag, "_hold_pr"}, pr, epr);
    chk({tag, "_hold_pi"}, pi, epi);
  endtask

  int v_ar[8] = '{1000, 1000, -5000, -5000, 32767, -32768, 3, 100};
  int v_ai[8] = '{2000, 2000, 7000, 7000, 32767, 0, -3, -100};
  int v_br[8] = '{3000, 3000, -20000, -20000, 131071, 131071, 5461, -300};
  int v_bi[8] = '{4000, 4000, 100000, 100000, 0, 0, 5461, -200};
  bit v_cj[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int e_pr[8] = '{-153, 336, -18311, 24414, 32767, -32768, 1, 0};
  int e_pi[8] = '{305, 61, -19531, 10986, 32767, 0, 0, 2};
  int e_ov[8] = '{0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    int sent, rcvd, seen;
    bit held, in_fire;
    logic signed [15:0] hpr, hpi;
    logic [7:0] hu;

    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_pr", pr, 0);
    chk("reset_pi", pi, 0);
    chk("reset_ovf", m_ovf, 0);
    chk("reset_user", m_user, 0);
    chk("reset_s_ready", s_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one("basic",      16384, 16384, 16384, 0,       1'b0, 8'h11, 8192,  8192,  0);
    run_one("jj",         0,     16384, 0,     16384,   1'b0, 8'h22, -8192, 0,     0);
    run_one("jj_conj",    0,     16384, 0,     16384,   1'b1, 8'h33, 8192,  0,     0);
    run_one("half_pos",   1,     0,     16384, 0,       1'b0, 8'h44, 1,     0,     0);
    run_one("half_neg",   -1,    0,     16384, 0,       1'b0, 8'h45, 0,     0,     0);
    run_one("sat_corner", -32768, -32768, -131072, -131072, 1'b0, 8'h46, 0, 32767, 1);
    run_one("sat_pos",    16384, 0,     65536, 0,       1'b0, 8'h47, 32767, 0,     1);

    // Back-to-back burst with a 10-cycle downstream stall in the middle.
    sent = 0;
    rcvd = 0;
    held = 1'b0;
    hpr = '0;
    hpi = '0;
    hu  = '0;
    for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
      m_ready = !(cyc >= 8 && cyc < 18);
      if (sent < 8) begin
        drive(v_ar[sent], v_ai[sent], v_br[sent], v_bi[sent], v_cj[sent], 8'hA0 + sent);
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_pr", pr, hpr);
        chk("stall_pi", pi, hpi);
        chk("stall_user", m_user, hu);
      end
      held = m_valid && !m_ready;
      hpr = pr;
      hpi = pi;
      hu  = m_user;
      in_fire = s_valid && s_ready;
      if (m_valid && m_ready) begin
        chk($sformatf("burst%0d_pr", rcvd), pr, e_pr[rcvd]);
        chk($sformatf("burst%0d_pi", rcvd), pi, e_pi[rcvd]);
        chk($sformatf("burst%0d_ovf", rcvd), m_ovf, e_ov[rcvd]);
        chk($sformatf("burst%0d_user", rcvd), m_user, 8'hA0 + rcvd);
        rcvd++;
      end
      @(posedge clk); #1;
      if (in_fire) sent++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("burst_count", rcvd, 8);
    @(posedge clk); #1;

    // Four samples in flight, then a single reset cycle.
    for (int k = 0; k < 4; k++) begin
      drive(16384, 16384, 16384, 0, 1'b0, 8'hC0 + k);
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_s_ready_during", s_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_pr", pr, 0);
    chk("rst_pi", pi, 0);
    chk("rst_ovf", m_ovf, 0);
    chk("rst_user", m_user, 0);
    chk("rst_s_ready_after", s_ready, 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    chk("rst_flushed", seen, 0);
    run_one("post_rst", 1000, 2000, 3000, 4000, 1'b1, 8'h5A, 336, 61, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
